// File: rtl/ag32gbd_bram_pkg.sv
// Shared constants, flip-state encoding and buffer address helper for the BRAM arbiter.
// Pure definitions with no latency or backpressure of their own.
package ag32gbd_bram_pkg;

    localparam int P_REG_WR = 0;
    localparam int P_BUF_WR = 1;
    localparam int P_REG_RD = 2;
    localparam int P_BUF_RD = 3;

    localparam logic [9:0] REG_BASE = 10'h200;
    localparam logic [9:0] BUF_A    = 10'h000;
    localparam logic [9:0] BUF_B    = 10'h100;

    typedef enum logic [1:0] {
        FL_IDLE = 2'd0,
        FL_PEND = 2'd1,
        FL_DONE = 2'd2
    } flip_state_e;

    // Bank 0 maps to buffer A and bank 1 to buffer B; the offset supplies the low byte.
    function automatic logic [9:0] buf_addr(input logic bank, input logic [9:0] off);
        return (bank ? BUF_B : BUF_A) | {2'b00, off[7:0]};
    endfunction

endpackage

// File: rtl/ag32gbd_rr_pick3.sv
// Combinational 3-way round-robin picker: the first eligible requester at or after ptr wins.
// Zero latency; masked requesters are skipped and keep waiting.
module ag32gbd_rr_pick3
    import ag32gbd_bram_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [2:0] mask_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] gnt_o,
    output logic [1:0] ptr_nxt_o
);

    logic [2:0] elig;

    assign elig = req_i & ~mask_i;

    // Scan from the farthest candidate back to ptr so the closest eligible one wins.
    always_comb begin
        logic [1:0] idx;
        gnt_o     = '0;
        ptr_nxt_o = ptr_i;
        idx       = '0;
        for (int k = 2; k >= 0; k--) begin
            idx = 2'((int'(ptr_i) + k) % 3);
            if (elig[idx]) begin
                gnt_o     = 3'b001 << idx;
                ptr_nxt_o = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/ag32gbd_bram_arbiter.sv
// Four-port arbiter for the single-port image/register BRAM with double-buffer bank flipping.
// Grants are combinational in the request cycle; read data follows one cycle after the grant.
module ag32gbd_bram_arbiter
    import ag32gbd_bram_pkg::P_REG_WR, ag32gbd_bram_pkg::P_BUF_WR,
           ag32gbd_bram_pkg::P_REG_RD, ag32gbd_bram_pkg::P_BUF_RD,
           ag32gbd_bram_pkg::flip_state_e, ag32gbd_bram_pkg::FL_IDLE,
           ag32gbd_bram_pkg::FL_PEND, ag32gbd_bram_pkg::FL_DONE,
           ag32gbd_bram_pkg::buf_addr;
#(
    parameter int         ADDR_W     = 10,
    parameter int         DATA_W     = 8,
    parameter logic [9:0] REG_BASE   = ag32gbd_bram_pkg::REG_BASE,
    parameter int         WAIT_LIMIT = 16
) (
    input  logic              sys_clock,
    input  logic              sys_reset,
    input  logic              reg_wr_req,
    input  logic [ADDR_W-1:0] reg_wr_addr,
    input  logic [DATA_W-1:0] reg_wr_data,
    output logic              reg_wr_ack,
    input  logic              buf_wr_req,
    input  logic [ADDR_W-1:0] buf_wr_off,
    input  logic [DATA_W-1:0] buf_wr_data,
    output logic              buf_wr_ack,
    input  logic              reg_rd_req,
    input  logic [ADDR_W-1:0] reg_rd_addr,
    output logic              reg_rd_ack,
    output logic              reg_rd_valid,
    input  logic              buf_rd_req,
    input  logic [ADDR_W-1:0] buf_rd_off,
    output logic              buf_rd_ack,
    output logic              buf_rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              flip_req,
    output logic              flip_done,
    output logic              wr_bank,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              err_addr,
    output logic [3:0]        stall_flag
);

    localparam int               CNT_W    = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(WAIT_LIMIT);

    flip_state_e      flip_q, flip_d;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic             rd_vld_q, rd_vld_d;
    logic             rd_buf_q, rd_buf_d;
    logic             rd_ill_q, rd_ill_d;
    logic             err_q, err_d;
    logic [3:0]       stall_q, stall_d;
    logic [CNT_W-1:0] wait_q [4];
    logic [CNT_W-1:0] wait_d [4];

    logic [3:0]       req;
    logic [3:0]       gnt;
    logic [3:0]       legal;
    logic [2:0]       rr_req;
    logic [2:0]       rr_mask;
    logic [2:0]       rr_gnt;
    logic [1:0]       rr_ptr_nxt;
    logic             flip_pending;
    logic             flip_fire;

    assign req = {buf_rd_req, reg_rd_req, buf_wr_req, reg_wr_req};

    assign legal[P_REG_WR] = (reg_wr_addr >= REG_BASE);
    assign legal[P_BUF_WR] = (buf_wr_off[ADDR_W-1:8] == '0);
    assign legal[P_REG_RD] = (reg_rd_addr >= REG_BASE);
    assign legal[P_BUF_RD] = (buf_rd_off[ADDR_W-1:8] == '0);

    // Flip FSM: state register
    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            flip_q <= FL_IDLE;
        end else begin
            flip_q <= flip_d;
        end
    end

    // Flip FSM: next state; a request while pending merges into the current flip
    always_comb begin
        flip_d = flip_q;
        case (flip_q)
            FL_IDLE: if (flip_req) flip_d = FL_PEND;
            FL_PEND: flip_d = FL_DONE;
            FL_DONE: flip_d = flip_req ? FL_PEND : FL_IDLE;
            default: flip_d = FL_IDLE;
        endcase
    end

    // Flip FSM: outputs
    always_comb begin
        flip_pending = (flip_q == FL_PEND);
        flip_fire    = (flip_q == FL_DONE);
    end

    // Register writes pre-empt everything; buffer ports sit out the pending cycle.
    assign rr_req  = req[3:1] & {3{~sys_reset & ~reg_wr_req}};
    assign rr_mask = {flip_pending, 1'b0, flip_pending};

    ag32gbd_rr_pick3 u_pick (
        .req_i     (rr_req),
        .mask_i    (rr_mask),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (rr_gnt),
        .ptr_nxt_o (rr_ptr_nxt)
    );

    assign gnt = {rr_gnt, reg_wr_req & ~sys_reset};

    assign reg_wr_ack = gnt[P_REG_WR];
    assign buf_wr_ack = gnt[P_BUF_WR];
    assign reg_rd_ack = gnt[P_REG_RD];
    assign buf_rd_ack = gnt[P_BUF_RD];

    always_comb begin
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_wdata = '0;
        if (gnt[P_REG_WR]) begin
            bram_en    = legal[P_REG_WR];
            bram_we    = legal[P_REG_WR];
            bram_addr  = reg_wr_addr;
            bram_wdata = reg_wr_data;
        end else if (gnt[P_BUF_WR]) begin
            bram_en    = legal[P_BUF_WR];
            bram_we    = legal[P_BUF_WR];
            bram_addr  = buf_addr(wr_bank_q, buf_wr_off);
            bram_wdata = buf_wr_data;
        end else if (gnt[P_REG_RD]) begin
            bram_en    = legal[P_REG_RD];
            bram_addr  = reg_rd_addr;
        end else if (gnt[P_BUF_RD]) begin
            bram_en    = legal[P_BUF_RD];
            bram_addr  = buf_addr(~wr_bank_q, buf_rd_off);
        end
    end

    always_comb begin
        wr_bank_d = wr_bank_q ^ flip_pending;
        rr_ptr_d  = (|rr_gnt) ? rr_ptr_nxt : rr_ptr_q;
        rd_vld_d  = gnt[P_REG_RD] | gnt[P_BUF_RD];
        rd_buf_d  = gnt[P_BUF_RD];
        rd_ill_d  = |(gnt[3:2] & ~legal[3:2]);
        err_d     = err_q | (|(gnt & ~legal));
        stall_d   = stall_q;
        for (int n = 0; n < 4; n++) begin
            if (!req[n] || gnt[n]) begin
                wait_d[n] = '0;
            end else if (wait_q[n] == WAIT_MAX) begin
                wait_d[n] = WAIT_MAX;
            end else begin
                wait_d[n] = wait_q[n] + 1'b1;
            end
            stall_d[n] = stall_q[n] | (wait_d[n] == WAIT_MAX);
        end
    end

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            wr_bank_q <= 1'b0;
            rr_ptr_q  <= 2'd0;
            rd_vld_q  <= 1'b0;
            rd_buf_q  <= 1'b0;
            rd_ill_q  <= 1'b0;
            err_q     <= 1'b0;
            stall_q   <= '0;
            for (int n = 0; n < 4; n++) wait_q[n] <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rr_ptr_q  <= rr_ptr_d;
            rd_vld_q  <= rd_vld_d;
            rd_buf_q  <= rd_buf_d;
            rd_ill_q  <= rd_ill_d;
            err_q     <= err_d;
            stall_q   <= stall_d;
            for (int n = 0; n < 4; n++) wait_q[n] <= wait_d[n];
        end
    end

    // Outputs read as zero in any reset cycle, including a read valid already in flight.
    assign reg_rd_valid = rd_vld_q & ~rd_buf_q & ~sys_reset;
    assign buf_rd_valid = rd_vld_q &  rd_buf_q & ~sys_reset;
    assign rd_data      = (rd_vld_q & ~rd_ill_q & ~sys_reset) ? bram_rdata : '0;
    assign flip_done    = flip_fire & ~sys_reset;
    assign wr_bank      = wr_bank_q & ~sys_reset;
    assign err_addr     = err_q & ~sys_reset;
    assign stall_flag   = stall_q & {4{~sys_reset}};

endmodule

// File: doc/ag32gbd_bram_arbiter.md
Name: ag32gbd_bram_arbiter

Overview:
Arbitrates the single-port image/register BRAM between four requesters: cart register writes, sensor buffer writes, camera register reads and RAM-writer buffer reads.
- Owns the double-buffer bank select (buffer A / buffer B) and applies buffer flips only at safe points.
- Translates buffer offsets into physical BRAM addresses.
- Sits between the cart-side, camera and RAM-write blocks and the raw BRAM primitive, all in the sys_clock domain.

Parameters:
ADDR_W, 10, BRAM address width
DATA_W, 8, BRAM data width
REG_BASE, 10'h200, first address of the register/compare-matrix region (region runs to 10'h3FF)
WAIT_LIMIT, 16, request-pending cycles before a stall flag is set

Ports:
sys_clock  in  1  system clock, all logic rising-edge
sys_reset  in  1  synchronous, active-high reset
reg_wr_req  in  1  port0: register write request, held until ack
reg_wr_addr  in  10  port0: absolute address
reg_wr_data  in  8  port0: write data
reg_wr_ack  out  1  port0: grant pulse
buf_wr_req  in  1  port1: buffer write request
buf_wr_off  in  10  port1: offset, bits[9:8] must be 0
buf_wr_data  in  8  port1: write data
buf_wr_ack  out  1  port1: grant pulse
reg_rd_req  in  1  port2: register read request
reg_rd_addr  in  10  port2: absolute address
reg_rd_ack  out  1  port2: grant pulse
reg_rd_valid  out  1  port2: read data valid
buf_rd_req  in  1  port3: buffer read request
buf_rd_off  in  10  port3: offset, bits[9:8] must be 0
buf_rd_ack  out  1  port3: grant pulse
buf_rd_valid  out  1  port3: read data valid
rd_data  out  8  shared read data, qualified by the *_rd_valid signals
flip_req  in  1  pulse: swap write/read buffers
flip_done  out  1  pulse: flip applied
wr_bank  out  1  current write bank; the read bank is ~wr_bank
bram_en, bram_we  out  1  BRAM strobes
bram_addr  out  10  BRAM address
bram_wdata  out  8  BRAM write data
bram_rdata  in  8  BRAM read data, 1-cycle latency
err_addr  out  1  sticky: illegal address or offset seen
stall_flag  out  4  sticky per port: wait reached WAIT_LIMIT

Behaviour:
- Reset: all outputs 0, wr_bank=0, flip_pending=0, round-robin pointer=port1, wait counters cleared.
- Handshake:
  - A requester holds req plus addr/data stable until ack.
  - ack is a single-cycle pulse in the grant cycle, combinational from the registered state and the current req.
  - req still high in the cycle after ack counts as a new request.
  - Dropping req before ack withdraws the request with no side effect.
- One grant per cycle, selected as follows:
  - port0 has absolute priority.
  - Otherwise round-robin among ports 1, 2, 3; the pointer moves to the port after the one granted.
  - While flip_pending=1, ports 1 and 3 are ineligible.
- Grant cycle outputs: bram_en=1, bram_we=1 for ports 0 and 1.
- Address mapping:
  - port0, port2: raw address.
  - port1: {2'b00, wr_bank, off[7:0]}.
  - port3: {2'b00, ~wr_bank, off[7:0]}.
- Illegal address handling:
  - Illegal means port0/2 address < REG_BASE, or port1/3 off[9:8] != 0.
  - The request is still acked, with bram_en=0.
  - err_addr is set.
  - For a read, the valid pulse still follows with rd_data=8'h00.
- Read latency: valid is asserted exactly 1 cycle after ack, with rd_data=bram_rdata (or 0 if illegal). Back-to-back reads stream at 1 per cycle.
- Flip sequence:
  - flip_req sets flip_pending.
  - In the next cycle, wr_bank toggles and flip_pending clears; no buffer port can be granted in that cycle.
  - flip_done pulses in the cycle after the toggle.
  - A flip_req while pending, or in the same cycle as the toggle, merges into the current flip (one toggle total).
  - A port3 read granted before the flip returns data from the old read bank.
- Wait counters:
  - Per port, a counter increments each cycle req=1 && ack=0, saturating at WAIT_LIMIT.
  - It clears on ack or when req=0.
  - Reaching WAIT_LIMIT sets stall_flag[n], which clears only on reset.
- Reset mid-operation: a pending read valid is dropped and a pending flip is discarded.

Decomposition:
- Package ag32gbd_bram_pkg holds:
  - port index constants P_REG_WR=0, P_BUF_WR=1, P_REG_RD=2, P_BUF_RD=3;
  - REG_BASE;
  - buffer region constants BUF_A=10'h000, BUF_B=10'h100.
- Sub-module ag32gbd_rr_pick3: 3-way round-robin picker (req[2:0], mask, ptr → one-hot grant, next ptr).

Test Plan:
- Reset, then a single buf_wr_req with off=0x05, data=0xA5 → ack in the same cycle; bram_addr=0x005, bram_we=1. Then buf_rd_req off=0x05 → ack, addr=0x105; valid 1 cycle later.
- Ports 1, 2, 3 requesting continuously (port0 idle) → grant order 1,2,3,1,2,3; no stall_flag after 100 cycles.
- port0 held high 20 cycles while port3 requests → reg_wr_ack every cycle; stall_flag[3]=1 after 16 cycles.
- flip_req during a continuous port1/port3 stream → exactly one cycle with no buffer grant; wr_bank 0→1; flip_done 1 cycle later. A second flip_req during pending → still exactly one toggle.
- reg_rd_addr=0x150 → ack, bram_en=0, reg_rd_valid 1 cycle later with rd_data=0x00; err_addr=1. Likewise buf_wr_off=0x1FF → ack, bram_en=0, err_addr=1.
- sys_reset asserted in the cycle after a port2 ack → no reg_rd_valid; all outputs 0; wr_bank=0.
